// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Framed byte-stream boot loader writing instruction memory and
//            holding the core in reset until a checksum-verified image lands.
// Revision : 1.0
// ============================================================================
module imem_loader #(
  parameter int          IROM_SPACE = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          TIMEOUT    = 1_000_000,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t          state_q;
  logic [7:0]      len_lo_q;
  logic [15:0]     len_q;
  logic [15:0]     idx_q;
  logic [7:0]      sum_q;
  logic [TW-1:0]   tcnt_q;
  logic            in_ready_q;
  logic            wr_en_q;
  logic [31:0]     wr_addr_q;
  logic [7:0]      wr_data_q;
  logic            cpu_hold_q;
  logic            load_done_q;
  logic            err_q;
  logic [1:0]      err_code_q;

  logic            xfer;
  logic [15:0]     frame_len;
  logic            in_frame;
  logic            timeout_hit;

  assign xfer        = in_valid & in_ready_q;
  assign frame_len   = {in_data, len_lo_q};
  assign in_frame    = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                       (state_q == S_DATA)   || (state_q == S_CSUM);
  // The TIMEOUT-th consecutive idle cycle is the one that aborts the frame.
  assign timeout_hit = in_frame && !xfer && (tcnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      len_lo_q    <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      tcnt_q      <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      wr_en_q     <= 1'b0;
      load_done_q <= 1'b0;
      in_ready_q  <= 1'b1;

      if (in_frame && !xfer) tcnt_q <= tcnt_q + TW'(1);
      else                   tcnt_q <= '0;

      case (state_q)
        S_IDLE: begin
          if (xfer && in_data == MAGIC) begin
            state_q    <= S_LEN_LO;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            sum_q      <= '0;
            idx_q      <= '0;
            cpu_hold_q <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_lo_q <= in_data;
            state_q  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_q <= frame_len;
            if ({16'd0, frame_len} > 32'(IROM_SPACE)) begin
              state_q    <= S_ERR;
              err_q      <= 1'b1;
              err_code_q <= 2'd1;
              in_ready_q <= 1'b0;
            end else if (frame_len == 16'd0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= BASE_ADDR + {16'd0, idx_q};
            wr_data_q <= in_data;
            sum_q     <= sum_q + in_data;
            idx_q     <= idx_q + 16'd1;
            if (idx_q == len_q - 16'd1) state_q <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (xfer) begin
            in_ready_q <= 1'b0;
            if (in_data == sum_q) begin
              state_q     <= S_DONE;
              load_done_q <= 1'b1;
              cpu_hold_q  <= 1'b0;
            end else begin
              state_q    <= S_ERR;
              err_q      <= 1'b1;
              err_code_q <= 2'd2;
            end
          end
        end
        S_DONE, S_ERR: state_q <= S_IDLE;
        default:       state_q <= S_IDLE;
      endcase

      if (timeout_hit) begin
        state_q    <= S_ERR;
        err_q      <= 1'b1;
        err_code_q <= 2'd3;
        in_ready_q <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed self-checking bench for imem_loader (TIMEOUT = 16).
// Revision : 1.0
// ============================================================================
module tb_imem_loader;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        err;
  logic [1:0]  err_code;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wa[$];
  logic [7:0]  wd[$];
  int          done_cnt = 0;

  imem_loader #(
    .IROM_SPACE (1024),
    .BASE_ADDR  (32'h0000_0000),
    .TIMEOUT    (16),
    .MAGIC      (8'hA5)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .err       (err),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
    if (load_done) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_byte_ready_wait: in_ready=%0b required=1 byte=%02h", in_ready, b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    done_cnt = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got=%0b exp=0", in_ready); end
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en: got=%0b exp=0", wr_en); end
    checks++; if (wr_addr !== 32'h0) begin failures++; $display("FAIL rst_wr_addr: got=%08h exp=0", wr_addr); end
    checks++; if (wr_data !== 8'h0) begin failures++; $display("FAIL rst_wr_data: got=%02h exp=0", wr_data); end
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL rst_cpu_hold: got=%0b exp=1", cpu_hold); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("FAIL rst_load_done: got=%0b exp=0", load_done); end
    checks++; if (err !== 1'b0 || err_code !== 2'd0) begin failures++; $display("FAIL rst_err: got=%0b/%0d exp=0/0", err, err_code); end
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready: got=%0b exp=1", in_ready); end
    clear_log();
  endtask

  task automatic test_basic_frame();
    logic [7:0] exp_d [4] = '{8'h13, 8'h00, 8'h00, 8'h00};
    clear_log();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL basic_hold_before_csum: got=%0b exp=1", cpu_hold); end
    send_byte(8'h13);
    checks++; if (load_done !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL basic_done_cycle: load_done=%0b in_ready=%0b cpu_hold=%0b exp=1/0/0", load_done, in_ready, cpu_hold);
    end
    repeat (3) @(negedge clk);
    checks++; if (wa.size() != 4) begin failures++; $display("FAIL basic_write_count: got=%0d exp=4", wa.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wa[i] !== 32'(i) || wd[i] !== exp_d[i]) begin
        failures++; $display("FAIL basic_write[%0d]: got=%08h:%02h exp=%08h:%02h", i, wa[i], wd[i], i, exp_d[i]);
      end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses: got=%0d exp=1", done_cnt); end
    checks++; if (cpu_hold !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL basic_final: cpu_hold=%0b err=%0b exp=0/0", cpu_hold, err); end
  endtask

  task automatic test_garbage_then_frame();
    clear_log();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    @(negedge clk);
    checks++; if (wa.size() != 0) begin failures++; $display("FAIL garbage_writes: got=%0d exp=0", wa.size()); end
    send_byte(8'hA5);
    checks++; if (cpu_hold !== 1'b1) begin failures++; $display("FAIL garbage_hold_reassert: got=%0b exp=1", cpu_hold); end
    send_byte(8'h02); send_byte(8'h00); send_byte(8'hAA); send_byte(8'h55); send_byte(8'hFF);
    repeat (3) @(negedge clk);
    checks++; if (wa.size() != 2) begin failures++; $display("FAIL garbage_write_count: got=%0d exp=2", wa.size()); end
    checks++; if (wa[0] !== 32'd0 || wd[0] !== 8'hAA) begin failures++; $display("FAIL garbage_write0: got=%08h:%02h exp=0:aa", wa[0], wd[0]); end
    checks++; if (wa[1] !== 32'd1 || wd[1] !== 8'h55) begin failures++; $display("FAIL garbage_write1: got=%08h:%02h exp=1:55", wa[1], wd[1]); end
    checks++; if (done_cnt != 1 || cpu_hold !== 1'b0) begin failures++; $display("FAIL garbage_done: pulses=%0d cpu_hold=%0b exp=1/0", done_cnt, cpu_hold); end
  endtask

  task automatic test_csum_error();
    clear_log();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
    checks++; if (err !== 1'b1 || err_code !== 2'd2 || in_ready !== 1'b0) begin
      failures++; $display("FAIL csum_err_cycle: err=%0b code=%0d in_ready=%0b exp=1/2/0", err, err_code, in_ready);
    end
    repeat (4) @(negedge clk);
    checks++; if (wa.size() != 2) begin failures++; $display("FAIL csum_write_count: got=%0d exp=2", wa.size()); end
    checks++; if (done_cnt != 0 || cpu_hold !== 1'b1) begin failures++; $display("FAIL csum_no_done: pulses=%0d cpu_hold=%0b exp=0/1", done_cnt, cpu_hold); end
    checks++; if (err !== 1'b1 || err_code !== 2'd2) begin failures++; $display("FAIL csum_sticky: err=%0b code=%0d exp=1/2", err, err_code); end
  endtask

  task automatic test_len_overflow();
    clear_log();
    send_byte(8'hA5);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ovf_magic_clears_err: got=%0b exp=0", err); end
    send_byte(8'h01); send_byte(8'h04);
    checks++; if (err !== 1'b1 || err_code !== 2'd1) begin failures++; $display("FAIL ovf_err: err=%0b code=%0d exp=1/1", err, err_code); end
    repeat (3) @(negedge clk);
    checks++; if (wa.size() != 0 || done_cnt != 0) begin failures++; $display("FAIL ovf_no_writes: writes=%0d pulses=%0d exp=0/0", wa.size(), done_cnt); end
  endtask

  task automatic test_timeout();
    clear_log();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h00); send_byte(8'h11);
    repeat (15) @(negedge clk);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL timeout_early: err=%0b exp=0 after 15 idle", err); end
    @(negedge clk);
    checks++; if (err !== 1'b1 || err_code !== 2'd3) begin failures++; $display("FAIL timeout_err: err=%0b code=%0d exp=1/3", err, err_code); end
    checks++; if (wa.size() != 1 || wd[0] !== 8'h11) begin failures++; $display("FAIL timeout_partial_write: n=%0d d=%02h exp=1/11", wa.size(), wd[0]); end
    // Sent during the ERR cycle, so the byte must be held until in_ready returns.
    send_byte(8'hA5);
    checks++; if (err !== 1'b0 || err_code !== 2'd0) begin failures++; $display("FAIL timeout_recover_clear: err=%0b code=%0d exp=0/0", err, err_code); end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h7E); send_byte(8'h7E);
    repeat (3) @(negedge clk);
    checks++; if (done_cnt != 1 || wa.size() != 2 || wd[1] !== 8'h7E || wa[1] !== 32'd0) begin
      failures++; $display("FAIL timeout_recover_frame: pulses=%0d writes=%0d last=%08h:%02h exp=1/2/0:7e", done_cnt, wa.size(), wa[1], wd[1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_log();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02);
    #2 rstn = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs: wr_en=%0b cpu_hold=%0b in_ready=%0b exp=0/1/0", wr_en, cpu_hold, in_ready);
    end
    @(negedge clk);
    rstn = 1'b1;
    checks++; if (wa.size() != 2) begin failures++; $display("FAIL midrst_writes: got=%0d exp=2", wa.size()); end
    clear_log();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    repeat (3) @(negedge clk);
    checks++; if (done_cnt != 1 || wa.size() != 0 || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL midrst_empty_frame: pulses=%0d writes=%0d cpu_hold=%0b exp=1/0/0", done_cnt, wa.size(), cpu_hold);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_garbage_then_frame();
    test_csum_error();
    test_len_overflow();
    test_timeout();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Byte-stream boot loader that writes a program image into the byte-addressed instruction memory through its write port, then releases the core. Sits between a UART receive stream (valid/ready byte interface) and the instruction memory write port. Holds the CPU in reset while loading and reports completion or error status.

Parameters:
IROM_SPACE, 1024, instruction memory size in bytes; maximum accepted image length.
BASE_ADDR, 32'h0000_0000, byte address where payload byte 0 is written.
TIMEOUT, 1_000_000, idle cycles allowed between bytes inside a frame before abort.
MAGIC, 8'hA5, frame start byte.

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
in_valid  input  1  byte available on in_data
in_data  input  8  received byte
in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready)
wr_en  output  1  instruction memory byte write strobe
wr_addr  output  32  byte write address
wr_data  output  8  byte write data
cpu_hold  output  1  hold core in reset while high
load_done  output  1  one-cycle pulse on successful load
err  output  1  sticky error flag
err_code  output  2  0 none, 1 length overflow, 2 checksum mismatch, 3 timeout

Behaviour:
- Reset (async, rstn low): state IDLE, in_ready=0 for that cycle, then 1; wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, load_done=0, err=0, err_code=0, counters=0.
- Frame: MAGIC, LEN_LO, LEN_HI (N = 16-bit little-endian byte count), N payload bytes, 1 checksum byte = sum of payload bytes mod 256.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE: non-MAGIC bytes accepted and discarded. MAGIC -> LEN_LO; clears err/err_code, clears running sum and index, sets cpu_hold=1.
- LEN_LO -> LEN_HI on transfer. LEN_HI: N > IROM_SPACE -> ERR (code 1); N == 0 -> CSUM; else -> DATA.
- DATA: each transfer writes payload byte i to BASE_ADDR+i; sum += byte (8-bit wrap); after byte N-1 -> CSUM.
- Write latency: wr_en high exactly one cycle, the cycle after the accepting edge, with registered wr_addr/wr_data; no back-pressure from memory.
- CSUM: byte == sum -> DONE; else -> ERR (code 2). Checksum byte never written to memory.
- DONE: one cycle; load_done=1, cpu_hold falls to 0 same cycle and stays 0; return to IDLE. in_ready=0 in DONE.
- ERR: one cycle, in_ready=0; err=1 with err_code latched; cpu_hold stays 1; return to IDLE. err remains set until next MAGIC accepted.
- Timeout: in LEN_LO, LEN_HI, DATA, CSUM, idle counter increments each cycle without a transfer, clears on transfer; reaching TIMEOUT -> ERR (code 3). Counter inactive in IDLE.
- Bytes already written before an error are not rolled back.
- A MAGIC-valued byte inside LEN/DATA/CSUM is treated as ordinary data.
- in_valid with in_ready=0 is not consumed; source must hold the byte.
- A new frame after DONE reasserts cpu_hold on its MAGIC and reloads.
- Reset mid-frame aborts immediately; no further writes; outputs to reset values.

Test Plan:
- Frame A5 04 00 13 00 00 00 13 -> writes 0x13,0x00,0x00,0x00 at addr 0..3 on four one-cycle wr_en pulses; load_done pulse; cpu_hold 1->0; err=0.
- Bytes 00 FF 12 then A5 02 00 AA 55 FF -> leading garbage ignored, no writes before magic; writes AA@0, 55@1; done.
- A5 02 00 AA 55 00 -> two writes, then err=1, err_code=2, cpu_hold stays 1, no load_done.
- A5 01 04 (N=1025) with IROM_SPACE=1024 -> ERR code 1, zero writes.
- TIMEOUT=16: A5 03 00 11, then idle 16 cycles -> ERR code 3 after exactly 16 idle cycles; a following valid frame clears err and completes.
- rstn low during DATA after 2 of 4 bytes -> wr_en=0 immediately, state IDLE, cpu_hold=1; A5 00 00 00 -> load_done with no writes.
